bus_xfer_ctrl: RTL and testbench

//  Upstream controller for the 8:1 common-bus multiplexer.
//  - Queues register-transfer requests {src,dst} and executes them in order.
//  - For each transfer, drives the bus select (src) and a one-hot destination load strobe (dst).
//  - Inserts wait cycles when the source is memory.
//  - Sits between the control unit and the bus mux / register load enables.

---
 rtl/mano_bus_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 46 ++++
 rtl/bus_xfer_ctrl.sv | 170 +++++++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mano_bus_pkg.sv
// Shared source/destination codes and FSM state encoding for the
// common-bus transfer controller (bus_xfer_ctrl) and its request FIFO.
package mano_bus_pkg;

  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    CODE_NONE = 3'd0,
    CODE_AR   = 3'd1,
    CODE_PC   = 3'd2,
    CODE_DR   = 3'd3,
    CODE_AC   = 3'd4,
    CODE_IR   = 3'd5,
    CODE_TR   = 3'd6,
    CODE_MEM  = 3'd7
  } bus_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRIVE = 2'd2
  } xfer_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through request FIFO with synchronous active-high reset;
// full/empty come from read/write pointers carrying one extra wrap bit.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  // storage and pointer update; writes blocked when full, reads when empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= {(AW+1){1'b0}};
      rd_q <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      if (push && !full) begin
        mem_q[wr_q[AW-1:0]] <= din;
        wr_q                <= wr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_q <= rd_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Queues {src,dst} bus transfers and sequences them onto the 8:1 common bus.
// Optional XFER_COUNT_EN adds xfer_cnt, a wrapping count of DRIVE cycles.
module bus_xfer_ctrl
  import mano_bus_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SEL_W    = mano_bus_pkg::SEL_W,
  parameter int MEM_SRC  = 7,
  parameter int MEM_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [SEL_W-1:0]      req_src,
  input  logic [SEL_W-1:0]      req_dst,
  output logic                  req_ready,
  output logic [SEL_W-1:0]      sel,
  output logic [(2**SEL_W)-1:0] ld,
  output logic                  busy,
  output logic                  done
`ifdef XFER_COUNT_EN
  ,
  output logic [15:0]           xfer_cnt
`endif
);

  localparam int NSRC = 2**SEL_W;
  localparam int FW   = 2*SEL_W;

  xfer_state_e      state_q;
  logic [SEL_W-1:0] src_q;
  logic [SEL_W-1:0] dst_q;
  logic [2:0]       wcnt_q;
  logic [SEL_W-1:0] sel_q;
  logic [NSRC-1:0]  ld_q;
  logic             done_q;

  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [FW-1:0]    head_s;
  logic [SEL_W-1:0] head_src_s;
  logic [SEL_W-1:0] head_dst_s;
  logic             head_mem_s;

  // Self-loads and "no destination" produce no strobe.
  function automatic logic [NSRC-1:0] load_strobe(input logic [SEL_W-1:0] s,
                                                  input logic [SEL_W-1:0] d);
    logic [NSRC-1:0] r;
    r = {NSRC{1'b0}};
    if ((d != {SEL_W{1'b0}}) && (d != s)) begin
      r[d] = 1'b1;
    end else begin
      r = {NSRC{1'b0}};
    end
    return r;
  endfunction

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({req_src, req_dst}),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign push_s     = req_valid && !full_s;
  assign head_src_s = head_s[FW-1:SEL_W];
  assign head_dst_s = head_s[SEL_W-1:0];
  assign head_mem_s = (head_src_s == SEL_W'(MEM_SRC)) && (MEM_WAIT > 0);

  assign req_ready  = !full_s;
  assign busy       = (state_q != ST_IDLE) || !empty_s;
  assign sel        = sel_q;
  assign ld         = ld_q;
  assign done       = done_q;

  // pop the head whenever the FSM is ready to start the next transfer
  always_comb begin
    pop_s = 1'b0;
    if (rst) begin
      pop_s = 1'b0;
    end else if (!empty_s && ((state_q == ST_IDLE) || (state_q == ST_DRIVE))) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // transfer FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= {SEL_W{1'b0}};
      dst_q   <= {SEL_W{1'b0}};
      wcnt_q  <= 3'd0;
      sel_q   <= {SEL_W{1'b0}};
      ld_q    <= {NSRC{1'b0}};
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DRIVE: begin
          if (pop_s) begin
            src_q <= head_src_s;
            dst_q <= head_dst_s;
            sel_q <= head_src_s;
            if (head_mem_s) begin
              state_q <= ST_WAIT;
              wcnt_q  <= 3'(MEM_WAIT);
              ld_q    <= {NSRC{1'b0}};
              done_q  <= 1'b0;
            end else begin
              state_q <= ST_DRIVE;
              ld_q    <= load_strobe(head_src_s, head_dst_s);
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
            sel_q   <= {SEL_W{1'b0}};
            ld_q    <= {NSRC{1'b0}};
            done_q  <= 1'b0;
          end
        end
        ST_WAIT: begin
          sel_q <= src_q;
          if (wcnt_q <= 3'd1) begin
            state_q <= ST_DRIVE;
            ld_q    <= load_strobe(src_q, dst_q);
            done_q  <= 1'b1;
          end else begin
            wcnt_q  <= wcnt_q - 3'd1;
            ld_q    <= {NSRC{1'b0}};
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sel_q   <= {SEL_W{1'b0}};
          ld_q    <= {NSRC{1'b0}};
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef XFER_COUNT_EN
  logic [15:0] xfer_cnt_q;

  assign xfer_cnt = xfer_cnt_q;

  // count DRIVE cycles, wrapping naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q <= 16'd0;
    end else if (state_q == ST_DRIVE) begin
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end else begin
      xfer_cnt_q <= xfer_cnt_q;
    end
  end
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: directed scenarios then random traffic,
// compared every cycle against a timeline model of each accepted transfer.
module tb_bus_xfer_ctrl;

  localparam int DEPTH    = 4;
  localparam int MEM_SRC  = 7;
  localparam int MEM_WAIT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_src;
  logic [2:0] req_dst;
  logic       req_ready;
  logic [2:0] sel;
  logic [7:0] ld;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_d = -100;

  // a = accept edge, p = pop edge, d = edge after which the DRIVE cycle is visible
  typedef struct {
    int src;
    int dst;
    int a;
    int p;
    int d;
  } xfer_t;
  xfer_t q[$];

  bus_xfer_ctrl #(
    .DEPTH    (DEPTH),
    .SEL_W    (3),
    .MEM_SRC  (MEM_SRC),
    .MEM_WAIT (MEM_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_ready (req_ready),
    .sel       (sel),
    .ld        (ld),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int fifo_count(int e);
    int n = 0;
    foreach (q[i]) if (q[i].p > e) n++;
    return n;
  endfunction

  task automatic check_all();
    logic [31:0] es, el, ed, eb, er;
    es = 32'd0; el = 32'd0; ed = 32'd0; eb = 32'd0;
    foreach (q[i]) begin
      if (q[i].p <= cyc && cyc <= q[i].d) begin
        eb = 32'd1;
        es = 32'(q[i].src);
        if (cyc == q[i].d) begin
          ed = 32'd1;
          if (q[i].dst != 0 && q[i].dst != q[i].src) el = 32'd1 << q[i].dst;
        end
      end
    end
    if (fifo_count(cyc) > 0) eb = 32'd1;
    er = (fifo_count(cyc) < DEPTH) ? 32'd1 : 32'd0;
    chk("sel", 32'(sel), es);
    chk("ld", 32'(ld), el);
    chk("done", 32'(done), ed);
    chk("busy", 32'(busy), eb);
    chk("req_ready", 32'(req_ready), er);
  endtask

  task automatic step(input logic v, input logic [2:0] s, input logic [2:0] d,
                      input logic r, output logic accepted);
    int p;
    int dd;
    req_valid = v; req_src = s; req_dst = d; rst = r;
    accepted  = v && !r && (fifo_count(cyc) < DEPTH);
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      last_d = -100;
    end else if (accepted) begin
      p  = (cyc + 1 > last_d + 1) ? cyc + 1 : last_d + 1;
      dd = p + ((int'(s) == MEM_SRC) ? MEM_WAIT : 0);
      last_d = dd;
      q.push_back('{int'(s), int'(d), cyc, p, dd});
    end
    while (q.size() > 0 && q[0].d < cyc - 2) void'(q.pop_front());
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input logic [2:0] s, input logic [2:0] d);
    logic acc;
    int n;
    n = 0;
    acc = 1'b0;
    do begin
      step(1'b1, s, d, 1'b0, acc);
      n++;
    end while (!acc && n < 64);
    chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 3'd0, 1'b0, acc);
  endtask

  initial begin
    logic       acc;
    logic       hv;
    logic       rr;
    logic       saw_full;
    logic [2:0] hs;
    logic [2:0] hd;

    req_valid = 1'b0; req_src = 3'd0; req_dst = 3'd0; rst = 1'b1;
    step(1'b0, 3'd0, 3'd0, 1'b1, acc);
    step(1'b0, 3'd0, 3'd0, 1'b1, acc);
    idle(3);

    // single transfer: DRIVE two cycles after acceptance, strobe gone next cycle
    send(3'd2, 3'd1);
    idle(1);
    chk("t2_ld", 32'(ld), 32'h02);
    chk("t2_done", 32'(done), 32'd1);
    idle(1);
    chk("t3_ld", 32'(ld), 32'h00);
    idle(2);

    // back-to-back register sources
    send(3'd4, 3'd3);
    send(3'd3, 3'd4);
    idle(4);

    // memory source inserts a wait cycle
    send(3'd7, 3'd5);
    idle(4);

    // memory stall fills the FIFO; held requests keep their order
    saw_full = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send(3'd7, 3'(i % 7));
      if (!req_ready) saw_full = 1'b1;
    end
    chk("saw_full", 32'(saw_full), 32'd1);
    idle(24);

    // suppressed loads, then reset mid-queue
    send(3'd4, 3'd4);
    send(3'd1, 3'd0);
    send(3'd7, 3'd2);
    send(3'd7, 3'd3);
    send(3'd7, 3'd4);
    step(1'b0, 3'd0, 3'd0, 1'b1, acc);
    chk("rst_busy", 32'(busy), 32'd0);
    idle(6);

    // random traffic with held requests and occasional resets
    hv = 1'b0; hs = 3'd0; hd = 3'd0;
    for (int i = 0; i < 800; i++) begin
      if (!hv && $urandom_range(0, 3) != 0) begin
        hv = 1'b1;
        hs = ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
        hd = 3'($urandom_range(0, 7));
      end
      rr = ($urandom_range(0, 99) == 0);
      step(hv, hs, hd, rr, acc);
      if (acc || rr) hv = 1'b0;
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
